// File: rtl/lane_cap_drain.sv
// Lane capacity drain: per-lane down-counters and the green-phase sequencer
// that serves lanes round-robin, draining each as cars pass.
module lane_cap_drain #(
    parameter int unsigned CAP_W       = 4,
    parameter int unsigned GAP_TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [8:0]       load_word,
    input  logic             start,
    input  logic             car_pass,
    output logic [3:0]       green,
    output logic [CAP_W-1:0] c1,
    output logic [CAP_W-1:0] c2,
    output logic [CAP_W-1:0] c3,
    output logic [CAP_W-1:0] c4,
    output logic [3:0]       cap_zero,
    output logic             busy,
    output logic             round_done
);

    localparam int unsigned N_LANES = 4;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned GAP_W   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_GREEN,
        S_CLEAR,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CAP_W-1:0]   cnt_q [N_LANES];
    logic [CAP_W-1:0]   cnt_d [N_LANES];
    logic [LANE_W-1:0]  ptr_q, ptr_d;
    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [3:0]         green_q, green_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sel_found;
    logic [LANE_W-1:0]  sel_lane;
    logic [CAP_W-1:0]   cur_cnt;
    logic               load_unused;

    // Bits 8:7 of the load word carry nothing for this stage.
    assign load_unused = ^load_word[8:7];

    // First nonzero lane at or after the pointer; descending scan so the nearest wins.
    always_comb begin
        sel_found = 1'b0;
        sel_lane  = ptr_q;
        for (int i = N_LANES - 1; i >= 0; i--) begin
            if (cnt_q[ptr_q + LANE_W'(i)] != '0) begin
                sel_found = 1'b1;
                sel_lane  = ptr_q + LANE_W'(i);
            end
        end
    end

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        lane_d  = lane_q;
        gap_d   = gap_q;
        cur_cnt = cnt_q[lane_q];
        green_d = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (load_word[6]) begin
                    cnt_d[load_word[5:4]] = CAP_W'(load_word[3:0]);
                end
                if (start) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (sel_found) begin
                    state_d = S_GREEN;
                    lane_d  = sel_lane;
                    gap_d   = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_GREEN: begin
                if (car_pass && (cur_cnt != '0)) begin
                    cnt_d[lane_q] = cur_cnt - CAP_W'(1);
                    gap_d         = '0;
                    if (cur_cnt == CAP_W'(1)) begin
                        state_d = S_CLEAR;
                        ptr_d   = lane_q + LANE_W'(1);
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                    if (gap_d == GAP_W'(GAP_TIMEOUT)) begin
                        state_d = S_CLEAR;
                        ptr_d   = lane_q + LANE_W'(1);
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_SELECT;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_GREEN) begin
            green_d[lane_d] = 1'b1;
        end
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < N_LANES; i++) begin
                cnt_q[i] <= '0;
            end
            ptr_q   <= '0;
            lane_q  <= '0;
            gap_q   <= '0;
            green_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            lane_q  <= lane_d;
            gap_q   <= gap_d;
            green_q <= green_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Zero flags straight from the count registers.
    always_comb begin
        cap_zero = '0;
        for (int i = 0; i < N_LANES; i++) begin
            cap_zero[i] = (cnt_q[i] == '0);
        end
    end

    assign green      = green_q;
    assign busy       = busy_q;
    assign round_done = done_q;
    assign c1         = cnt_q[0];
    assign c2         = cnt_q[1];
    assign c3         = cnt_q[2];
    assign c4         = cnt_q[3];

endmodule

// File: tb/tb_lane_cap_drain.sv
// Scoreboard bench for lane_cap_drain: a round-level model predicts the
// sequence of served lanes and counts; a monitor checks them as they appear.
module tb_lane_cap_drain;

    localparam int unsigned CAP_W       = 4;
    localparam int unsigned GAP_TIMEOUT = 8;

    logic             clk;
    logic             rst_n;
    logic [8:0]       load_word;
    logic             start;
    logic             car_pass;
    logic [3:0]       green;
    logic [CAP_W-1:0] c1, c2, c3, c4;
    logic [3:0]       cap_zero;
    logic             busy;
    logic             round_done;

    lane_cap_drain #(.CAP_W(CAP_W), .GAP_TIMEOUT(GAP_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .load_word(load_word), .start(start),
        .car_pass(car_pass), .green(green), .c1(c1), .c2(c2), .c3(c3), .c4(c4),
        .cap_zero(cap_zero), .busy(busy), .round_done(round_done)
    );

    typedef struct {
        bit          is_done;
        int          lane;
        logic [3:0]  grn;
        int          cnt;
        logic [15:0] cnts;
        logic [3:0]  zf;
    } exp_t;

    typedef struct {
        int cars;
        bit to;
    } plan_t;

    exp_t       exp_q[$];
    plan_t      plan_q[$];
    int         m_cnt[4];
    int         m_ptr;
    int         n_vec;
    int         n_err;
    bit         mon_en;
    logic [3:0] green_prev;
    int         gap_max;
    bit         inject;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] get_c(input int l);
        case (l)
            0:       return c1;
            1:       return c2;
            2:       return c3;
            default: return c4;
        endcase
    endfunction

    function automatic logic [15:0] model_cnts();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'(m_cnt[i]);
        return v;
    endfunction

    function automatic logic [3:0] model_zero();
        logic [3:0] z;
        for (int i = 0; i < 4; i++) z[i] = (m_cnt[i] == 0);
        return z;
    endfunction

    // Plays one whole round at transaction level: lanes in round-robin order,
    // each served until drained or abandoned after an idle gap.
    task automatic model_round(input int force_cars, input bit rand_to,
                               output bit first_done, output logic [3:0] first_grn);
        int    l, n, cars, tos;
        bit    found, to, first;
        exp_t  e;
        plan_t p;
        tos = 0;
        first = 1'b1;
        first_done = 1'b0;
        first_grn = 4'b0;
        while (1'b1) begin
            found = 1'b0;
            l = 0;
            for (int i = 0; i < 4; i++) begin
                if (!found && m_cnt[(m_ptr + i) % 4] != 0) begin
                    found = 1'b1;
                    l = (m_ptr + i) % 4;
                end
            end
            if (!found) begin
                e.is_done = 1'b1;
                e.lane = 0;
                e.grn = 4'b0;
                e.cnt = 0;
                e.cnts = model_cnts();
                e.zf = model_zero();
                exp_q.push_back(e);
                if (first) first_done = 1'b1;
                return;
            end
            n = m_cnt[l];
            if (first && force_cars >= 0 && force_cars < n) begin
                cars = force_cars;
                to = 1'b1;
            end else if (rand_to && tos < 3 && $urandom_range(0, 3) == 0) begin
                cars = int'($urandom_range(0, n - 1));
                to = 1'b1;
                tos++;
            end else begin
                cars = n;
                to = 1'b0;
            end
            m_cnt[l] = m_cnt[l] - cars;
            m_ptr = (l + 1) % 4;
            e.is_done = 1'b0;
            e.lane = l;
            e.grn = 4'(1 << l);
            e.cnt = m_cnt[l];
            e.cnts = model_cnts();
            e.zf = model_zero();
            exp_q.push_back(e);
            p.cars = cars;
            p.to = to;
            plan_q.push_back(p);
            if (first) begin
                first_grn = e.grn;
                first = 1'b0;
            end
        end
    endtask

    // Monitor: compares each green phase and each round completion to the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && rst_n) begin
            if (green_prev == 4'b0 && green != 4'b0) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) chk("green_unexpected", 32'(green), 32'd0);
                else chk("green_lane", 32'(green), 32'(exp_q[0].grn));
            end else if (green_prev != 4'b0 && green != 4'b0) begin
                chk("green_stable", 32'(green), 32'(green_prev));
            end
            if (green_prev != 4'b0 && green == 4'b0) begin
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    chk("phase_end_unexpected", 32'(green_prev), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("phase_count", 32'(get_c(e.lane)), 32'(e.cnt));
                    chk("phase_all_counts", 32'({c4, c3, c2, c1}), 32'(e.cnts));
                end
            end
            if (round_done) begin
                if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_counts", 32'({c4, c3, c2, c1}), 32'(e.cnts));
                    chk("done_cap_zero", 32'(cap_zero), 32'(e.zf));
                    chk("done_green", 32'(green), 32'd0);
                end
            end
        end
        green_prev = green;
    end

    task automatic do_load(input int l, input int cap, input int hold);
        load_word = {2'($urandom_range(0, 3)), 1'b1, 2'(l), 4'(cap)};
        repeat (hold) @(negedge clk);
        load_word = '0;
        m_cnt[l] = cap;
        chk("load_count", 32'(get_c(l)), 32'(cap));
    endtask

    // Drives one green phase: a given number of car passes, optionally followed by silence.
    task automatic drive_phase(input int cars, input bit to, input bit stray);
        int t;
        int g;
        t = 0;
        while (green == 4'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (green == 4'b0) begin
            chk("green_wait_timeout", 32'd0, 32'd1);
            return;
        end
        if (inject) begin
            load_word = 9'h17F;
            start = 1'b1;
            @(negedge clk);
            load_word = '0;
            start = 1'b0;
        end
        for (int c = 0; c < cars; c++) begin
            g = int'($urandom_range(0, gap_max));
            for (int k = 0; k < g; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    load_word = 9'h040 | 9'($urandom_range(0, 63));
                    start = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                load_word = '0;
                start = 1'b0;
            end
            car_pass = 1'b1;
            @(negedge clk);
            car_pass = 1'b0;
        end
        t = 0;
        while (green != 4'b0 && t < int'(GAP_TIMEOUT) + 4) begin
            @(negedge clk);
            t++;
        end
        if (green != 4'b0) chk("green_drop_timeout", 32'(green), 32'd0);
        if (to) chk("timeout_idle_len_ok", 32'(t <= int'(GAP_TIMEOUT)), 32'd1);
        if (stray) begin
            car_pass = 1'b1;
            @(negedge clk);
            @(negedge clk);
            car_pass = 1'b0;
        end
    endtask

    task automatic run_round(input int force_cars, input bit rand_to, input bit stray, input logic [8:0] lw);
        bit         fd;
        logic [3:0] fg;
        plan_t      p;
        int         t;
        if (lw[6]) m_cnt[lw[5:4]] = int'(lw[3:0]);
        model_round(force_cars, rand_to, fd, fg);
        load_word = lw;
        start = 1'b1;
        @(negedge clk);
        load_word = '0;
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("green_in_select", 32'(green), 32'd0);
        @(negedge clk);
        if (fd) chk("done_latency", 32'(round_done), 32'd1);
        else chk("green_latency", 32'(green), 32'(fg));
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            drive_phase(p.cars, p.to, stray);
        end
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("round_idle", 32'(busy), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int         t;
        logic [8:0] lw;
        n_vec = 0;
        n_err = 0;
        mon_en = 1'b1;
        green_prev = 4'b0;
        gap_max = 0;
        inject = 1'b0;
        rst_n = 1'b0;
        load_word = '0;
        start = 1'b0;
        car_pass = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_ptr = 0;

        repeat (2) @(negedge clk);
        chk("rst_green", 32'(green), 32'd0);
        chk("rst_counts", 32'({c4, c3, c2, c1}), 32'd0);
        chk("rst_cap_zero", 32'(cap_zero), 32'hF);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_round_done", 32'(round_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // lane1=3, lane3=2, a car every green cycle
        do_load(0, 3, 1);
        do_load(2, 2, 1);
        run_round(-1, 1'b0, 1'b0, 9'h000);

        // lane2=5, two cars then silence; lane2 is served again after the wrap
        gap_max = 3;
        do_load(1, 5, 2);
        run_round(2, 1'b0, 1'b0, 9'h000);

        // nothing loaded: straight to DONE
        run_round(-1, 1'b0, 1'b0, 9'h000);

        // load and start during GREEN are ignored; car_pass in CLEAR/SELECT is ignored
        do_load(0, 2, 1);
        inject = 1'b1;
        run_round(-1, 1'b0, 1'b1, 9'h000);
        inject = 1'b0;
        load_word = 9'h17F;
        @(negedge clk);
        load_word = '0;
        m_cnt[3] = 15;
        chk("c4_load_in_idle", 32'(c4), 32'd15);

        // reset in the middle of a green phase
        do_load(0, 2, 1);
        for (int l = 1; l < 4; l++) do_load(l, 0, 1);
        mon_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (green == 4'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("pre_reset_green", 32'(green), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_green", 32'(green), 32'd0);
        chk("async_rst_c1", 32'(c1), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_cap_zero", 32'(cap_zero), 32'hF);
        chk("async_rst_round_done", 32'(round_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_ptr = 0;
        exp_q.delete();
        plan_q.delete();
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_green", 32'(green), 32'd0);
        mon_en = 1'b1;

        // randomized rounds
        gap_max = 6;
        for (int r = 0; r < 25; r++) begin
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 9) < 6) do_load(l, int'($urandom_range(0, 15)), int'($urandom_range(1, 2)));
            end
            lw = 9'h000;
            if ($urandom_range(0, 1) == 1) lw = {2'($urandom_range(0, 3)), 1'b1, 6'($urandom_range(0, 63))};
            run_round(-1, 1'b1, 1'($urandom_range(0, 1)), lw);
        end

        repeat (5) @(negedge clk);
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
